led_tick_sequencer: RTL and testbench

//  Consumes the slow square wave from the clock divider and drives an LED pattern.

---
 rtl/led_tick_pkg.sv | 36 +++
 rtl/edge_sync.sv | 33 +++
 rtl/led_tick_sequencer.sv | 128 ++++++++++++
 tb/tb_led_tick_sequencer.sv | 271 +++++++++++++++++++++++++++
 4 files changed

// File: rtl/led_tick_pkg.sv
// Shared encodings and the pattern-initialisation helper for the LED tick sequencer.
package led_tick_pkg;

  // Widest LED bank the helper function can describe.
  localparam int MAX_LEDS = 32;

  typedef enum logic [1:0] {
    MODE_CHASE  = 2'd0,
    MODE_BOUNCE = 2'd1,
    MODE_BLINK  = 2'd2,
    MODE_COUNT  = 2'd3
  } mode_e;

  typedef enum logic [1:0] {
    IDLE  = 2'd0,
    RUN   = 2'd1,
    PAUSE = 2'd2
  } state_e;

  typedef enum logic {
    LEFT  = 1'b0,
    RIGHT = 1'b1
  } dir_e;

  // Starting pattern for a mode on an n-wide LED bank (upper bits beyond n are zero).
  function automatic logic [MAX_LEDS-1:0] init_pattern(input mode_e mode, input int unsigned n);
    logic [MAX_LEDS:0] ones;
    ones = ((MAX_LEDS+1)'(1) << n) - (MAX_LEDS+1)'(1);
    case (mode)
      MODE_CHASE, MODE_BOUNCE: init_pattern = MAX_LEDS'(1);
      MODE_BLINK:              init_pattern = ones[MAX_LEDS-1:0];
      default:                 init_pattern = '0;
    endcase
  endfunction

endpackage

// File: rtl/edge_sync.sv
// Synchronizes the divider square wave and emits a one-cycle pulse per qualifying edge.
module edge_sync #(
  parameter int STAGES     = 2,
  parameter bit BOTH_EDGES = 1'b0
) (
  input  logic CLK,
  input  logic RST,
  input  logic din,
  output logic pulse
);

  logic [STAGES-1:0] sync_q;
  logic              hist_q;
  logic              synced;

  assign synced = sync_q[STAGES-1];

  // Synchronizer chain, one-flop history and registered edge pulse.
  always_ff @(posedge CLK) begin
    if (RST) begin
      sync_q <= '0;
      hist_q <= 1'b0;
      pulse  <= 1'b0;
    end else begin
      // NOTE: non-blocking assignments make every flop sample the pre-edge value,
      // so the chain shifts one stage per clock instead of collapsing.
      sync_q <= {sync_q[STAGES-2:0], din};
      hist_q <= synced;
      pulse  <= BOTH_EDGES ? (synced ^ hist_q) : (synced & ~hist_q);
    end
  end

endmodule

// File: rtl/led_tick_sequencer.sv
// LED pattern sequencer: advances chase/bounce/blink/count patterns on divider ticks.
module led_tick_sequencer
  import led_tick_pkg::*;
#(
  parameter int NUM_LEDS    = 5,
  parameter int SYNC_STAGES = 2,
  parameter int EDGE_MODE   = 0
) (
  input  logic                CLK,
  input  logic                RST,
  input  logic                tick_in,
  input  logic                enable,
  input  logic [1:0]          mode,
  output logic [NUM_LEDS-1:0] leds,
  output logic                step,
  output logic                wrap
);

  localparam logic [NUM_LEDS-1:0] ALL_ONES = '1;

  logic                qual_edge;
  state_e              state;
  mode_e               mode_q;
  mode_e               mode_in;
  dir_e                dir;
  logic                mode_change;
  logic [NUM_LEDS-1:0] init_leds;
  logic [NUM_LEDS-1:0] next_leds;
  dir_e                next_dir;
  logic                next_wrap;

  edge_sync #(
    .STAGES    (SYNC_STAGES),
    .BOTH_EDGES(EDGE_MODE != 0)
  ) u_edge_sync (
    .CLK  (CLK),
    .RST  (RST),
    .din  (tick_in),
    .pulse(qual_edge)
  );

  assign mode_in     = mode_e'(mode);
  assign mode_change = (mode_in != mode_q);
  assign init_leds   = NUM_LEDS'(init_pattern(mode_in, NUM_LEDS));

  // Next pattern, direction and wrap flag for one step of the latched mode.
  always_comb begin
    // NOTE: every output gets a default first so no path leaves it unassigned,
    // which would otherwise infer a latch.
    next_leds = leds;
    next_dir  = dir;
    next_wrap = 1'b0;
    case (mode_q)
      MODE_CHASE: begin
        next_leds = {leds[NUM_LEDS-2:0], leds[NUM_LEDS-1]};
        next_wrap = leds[NUM_LEDS-1];
      end
      MODE_BOUNCE: begin
        next_leds = (dir == LEFT) ? (leds << 1) : (leds >> 1);
        if (next_leds[NUM_LEDS-1]) begin
          next_dir = RIGHT;
        end else if (next_leds[0]) begin
          next_dir  = LEFT;
          next_wrap = 1'b1;
        end
      end
      MODE_BLINK: begin
        next_leds = ~leds;
        next_wrap = (~leds == ALL_ONES);
      end
      MODE_COUNT: begin
        next_leds = leds + NUM_LEDS'(1);
        next_wrap = (leds == ALL_ONES);
      end
      default: ;
    endcase
  end

  // Sequencer FSM with registered pattern, direction, latched mode and pulses.
  always_ff @(posedge CLK) begin
    if (RST) begin
      state  <= IDLE;
      mode_q <= MODE_CHASE;
      dir    <= LEFT;
      leds   <= '0;
      step   <= 1'b0;
      wrap   <= 1'b0;
    end else begin
      step <= 1'b0;
      wrap <= 1'b0;
      if (state != IDLE && mode_change) begin
        // A mode change reloads the pattern and swallows any edge in this cycle.
        leds   <= init_leds;
        dir    <= LEFT;
        mode_q <= mode_in;
      end else begin
        case (state)
          IDLE: begin
            leds   <= '0;
            mode_q <= mode_in;
            if (enable) begin
              state <= RUN;
              leds  <= init_leds;
              dir   <= LEFT;
            end
          end
          RUN: begin
            // Pausing takes priority over a coincident edge.
            if (!enable) begin
              state <= PAUSE;
            end else if (qual_edge) begin
              leds <= next_leds;
              dir  <= next_dir;
              step <= 1'b1;
              wrap <= next_wrap;
            end
          end
          PAUSE: begin
            // Edges seen while paused are dropped, not queued.
            if (enable) state <= RUN;
          end
          default: state <= IDLE;
        endcase
      end
    end
  end

endmodule

// File: tb/tb_led_tick_sequencer.sv
// Self-checking bench: directed scenarios plus random traffic against a position-based model.
module tb_led_tick_sequencer;
  import led_tick_pkg::*;

  localparam int N = 5;
  localparam int S = 2;

  logic         CLK = 1'b0;
  logic         RST;
  logic         tick_in;
  logic         enable;
  logic [1:0]   mode;
  logic [N-1:0] leds0, leds1;
  logic         step0, step1, wrap0, wrap1;

  int total = 0;
  int bad   = 0;

  // Reference model: per-DUT state, pattern position and expected outputs.
  int m_state [2];
  int m_mode_q[2];
  int m_pos   [2];
  int m_leds  [2];
  bit m_step  [2];
  bit m_wrap  [2];
  bit samp    [S+2];

  logic [N-1:0] log_leds[$];
  bit           log_wrap[$];

  led_tick_sequencer #(.NUM_LEDS(N), .SYNC_STAGES(S), .EDGE_MODE(0)) dut0 (
    .CLK(CLK), .RST(RST), .tick_in(tick_in), .enable(enable), .mode(mode),
    .leds(leds0), .step(step0), .wrap(wrap0)
  );

  led_tick_sequencer #(.NUM_LEDS(N), .SYNC_STAGES(S), .EDGE_MODE(1)) dut1 (
    .CLK(CLK), .RST(RST), .tick_in(tick_in), .enable(enable), .mode(mode),
    .leds(leds1), .step(step1), .wrap(wrap1)
  );

  always #5 CLK = ~CLK;

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    total++;
    assert (obs === exp) else begin
      bad++;
      $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  function automatic int period(input int md);
    case (md)
      0:       return N;
      1:       return 2 * N - 2;
      2:       return 2;
      default: return 1 << N;
    endcase
  endfunction

  function automatic int pattern(input int md, input int p);
    case (md)
      0:       return 1 << p;
      1:       return (p < N) ? (1 << p) : (1 << (2 * N - 2 - p));
      2:       return (p == 0) ? ((1 << N) - 1) : 0;
      default: return p;
    endcase
  endfunction

  // Advance the model by one clock using the inputs as they were at this edge.
  task automatic model_step();
    bit rise, anye, qe;
    int md;
    rise = samp[S] && !samp[S+1];
    anye = samp[S] != samp[S+1];
    for (int j = S + 1; j > 0; j--) samp[j] = samp[j-1];
    samp[0] = tick_in && !RST;
    if (RST) for (int j = 0; j < S + 2; j++) samp[j] = 1'b0;
    md = int'(mode);
    for (int i = 0; i < 2; i++) begin
      qe = (i == 1) ? anye : rise;
      m_step[i] = 1'b0;
      m_wrap[i] = 1'b0;
      if (RST) begin
        m_state[i] = 0; m_mode_q[i] = 0; m_pos[i] = 0; m_leds[i] = 0;
      end else if (m_state[i] == 0) begin
        m_mode_q[i] = md;
        if (enable) begin
          m_state[i] = 1; m_pos[i] = 0; m_leds[i] = pattern(md, 0);
        end
      end else if (md != m_mode_q[i]) begin
        m_mode_q[i] = md; m_pos[i] = 0; m_leds[i] = pattern(md, 0);
      end else if (m_state[i] == 1) begin
        if (!enable) begin
          m_state[i] = 2;
        end else if (qe) begin
          m_pos[i]  = (m_pos[i] + 1) % period(md);
          m_leds[i] = pattern(md, m_pos[i]);
          m_step[i] = 1'b1;
          m_wrap[i] = (m_pos[i] == 0);
        end
      end else if (enable) begin
        m_state[i] = 1;
      end
    end
  endtask

  // One clock: model update at the edge, DUT outputs compared 1 time unit later.
  task automatic cycle();
    @(posedge CLK);
    model_step();
    #1;
    check("leds0", 32'(leds0), 32'(m_leds[0]));
    check("step0", 32'(step0), 32'(m_step[0]));
    check("wrap0", 32'(wrap0), 32'(m_wrap[0]));
    check("leds1", 32'(leds1), 32'(m_leds[1]));
    check("step1", 32'(step1), 32'(m_step[1]));
    check("wrap1", 32'(wrap1), 32'(m_wrap[1]));
    if (step0 === 1'b1) begin
      log_leds.push_back(leds0);
      log_wrap.push_back(wrap0);
    end
  endtask

  task automatic pulse_tick();
    tick_in = 1'b1;
    repeat (5) cycle();
    tick_in = 1'b0;
    repeat (5) cycle();
  endtask

  logic [N-1:0] exp_chase [5] = '{5'b00010, 5'b00100, 5'b01000, 5'b10000, 5'b00001};
  logic [N-1:0] exp_bounce[8] = '{5'b00010, 5'b00100, 5'b01000, 5'b10000,
                                  5'b01000, 5'b00100, 5'b00010, 5'b00001};

  initial begin
    int n;
    int lat;
    int r;
    bit found;

    RST = 1'b1; tick_in = 1'b0; enable = 1'b0; mode = 2'd0;
    repeat (2) cycle();
    RST = 1'b0;
    cycle();

    // Chase: load without step, then five rising edges.
    enable = 1'b1;
    cycle();
    check("chase_load", 32'(leds0), 32'(5'b00001));
    check("chase_load_step", 32'(step0), 32'd0);
    log_leds.delete(); log_wrap.delete();
    repeat (5) pulse_tick();
    check("chase_count", 32'(log_leds.size()), 32'd5);
    for (int i = 0; i < 5 && i < log_leds.size(); i++) begin
      check("chase_leds", 32'(log_leds[i]), 32'(exp_chase[i]));
      check("chase_wrap", 32'(log_wrap[i]), (i == 4) ? 32'd1 : 32'd0);
    end

    // Reset held three cycles mid-run.
    RST = 1'b1;
    cycle();
    check("rst_leds", 32'(leds0), 32'd0);
    check("rst_step", 32'(step0), 32'd0);
    check("rst_wrap", 32'(wrap0), 32'd0);
    repeat (2) cycle();

    // Bounce: eight rising edges cover one full period.
    mode = 2'd1;
    RST  = 1'b0;
    cycle();
    check("bounce_load", 32'(leds0), 32'(5'b00001));
    log_leds.delete(); log_wrap.delete();
    repeat (8) pulse_tick();
    check("bounce_count", 32'(log_leds.size()), 32'd8);
    for (int i = 0; i < 8 && i < log_leds.size(); i++) begin
      check("bounce_leds", 32'(log_leds[i]), 32'(exp_bounce[i]));
      check("bounce_wrap", 32'(log_wrap[i]), (i == 7) ? 32'd1 : 32'd0);
    end

    // Count on the both-edges instance: 31 toggles, then a single 0->1 wraps.
    tick_in = 1'b1;
    repeat (5) cycle();
    mode = 2'd3;
    repeat (6) cycle();
    repeat (31) begin
      tick_in = ~tick_in;
      repeat (5) cycle();
    end
    check("count_full", 32'(leds1), 32'(5'b11111));
    tick_in = 1'b1;
    n = 0; lat = 0; found = 1'b0;
    repeat (10) begin
      cycle();
      n++;
      if (step1 === 1'b1 && !found) begin
        found = 1'b1;
        lat   = n - 1;
        check("count_wrap_leds", 32'(leds1), 32'd0);
        check("count_wrap_flag", 32'(wrap1), 32'd1);
      end
    end
    check("count_step_seen", 32'(found), 32'd1);
    check("count_latency", 32'(lat), 32'(S + 1));

    // Pause holds, drops edges, and resumes from the held value.
    mode = 2'd0;
    cycle();
    tick_in = 1'b0;
    repeat (5) cycle();
    pulse_tick();
    check("pre_pause", 32'(leds0), 32'(5'b00010));
    enable = 1'b0;
    cycle();
    log_leds.delete(); log_wrap.delete();
    repeat (2) pulse_tick();
    check("pause_steps", 32'(log_leds.size()), 32'd0);
    check("pause_hold", 32'(leds0), 32'(5'b00010));
    enable = 1'b1;
    cycle();
    log_leds.delete(); log_wrap.delete();
    pulse_tick();
    check("resume_steps", 32'(log_leds.size()), 32'd1);
    check("resume_leds", 32'(leds0), 32'(5'b00100));

    // Mode change lands on the same cycle as a qualified edge.
    log_leds.delete(); log_wrap.delete();
    tick_in = 1'b1;
    repeat (3) cycle();
    mode = 2'd2;
    cycle();
    check("race_leds", 32'(leds0), 32'(5'b11111));
    check("race_step", 32'(step0), 32'd0);
    repeat (6) cycle();
    check("race_dropped", 32'(log_leds.size()), 32'd0);
    check("race_hold", 32'(leds0), 32'(5'b11111));

    // Enable drops on the same cycle as a qualified edge.
    tick_in = 1'b0;
    repeat (5) cycle();
    tick_in = 1'b1;
    repeat (3) cycle();
    enable = 1'b0;
    cycle();
    check("drop_step", 32'(step0), 32'd0);
    check("drop_leds", 32'(leds0), 32'(5'b11111));
    check("drop_state", 32'(dut0.state), 32'(PAUSE));
    enable = 1'b1;
    cycle();
    check("drop_resume", 32'(leds0), 32'(5'b11111));
    tick_in = 1'b0;
    repeat (5) cycle();
    log_leds.delete(); log_wrap.delete();
    pulse_tick();
    check("drop_next_steps", 32'(log_leds.size()), 32'd1);
    check("drop_next_leds", 32'(leds0), 32'd0);

    // Random traffic against the model.
    repeat (400) begin
      r = int'($urandom_range(0, 99));
      if (r < 25) tick_in = ~tick_in;
      if (r >= 90 && r < 95) enable = ~enable;
      if (r >= 95 && r < 99) mode = 2'($urandom_range(0, 3));
      RST = (r == 99);
      cycle();
    end

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
